// File: rtl/sound_arbiter.sv
// rtl/sound_arbiter.sv - shares the single note player among N_REQ requesters.
// Define SOUND_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module sound_arbiter #(
    parameter int N_REQ   = 3,
    parameter int OCT_W   = 3,
    parameter int NOTE_W  = 3,
    parameter int LEN_W   = 3,
    parameter int TIMEOUT = 200_000_000,
    parameter int TO_W    = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*OCT_W-1:0]    req_octave,
    input  logic [N_REQ*NOTE_W-1:0]   req_note,
    input  logic [N_REQ*LEN_W-1:0]    req_length,
    input  logic                      snd_over,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic                      abort,
    output logic                      snd_start,
    output logic [OCT_W-1:0]          snd_octave,
    output logic [NOTE_W-1:0]         snd_note,
    output logic [LEN_W-1:0]          snd_length,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_PLAY,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [OCT_W-1:0]    oct_q, oct_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [TO_W-1:0]     wd_q, wd_d, wd_inc;
    logic                abort_q, abort_d;
    logic [IDX_W-1:0]    win_idx;
    logic                expired;

`ifdef SOUND_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] own_idx;

    // Scan from ptr_q upward with wrap; descending loop lets the nearest hit win.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] sel;
        idx     = 0;
        sel     = '0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            sel = IDX_W'(idx);
            if (req[sel]) win_idx = sel;
        end
    end

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) own_idx = IDX_W'(i);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_FINISH) begin
            ptr_d = (own_idx == IDX_W'(N_REQ - 1)) ? '0 : own_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = IDX_W'(i);
        end
    end
`endif

    assign wd_inc  = (wd_q == '1) ? wd_q : wd_q + TO_W'(1);
    assign expired = (wd_q >= WD_LAST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        oct_d   = oct_q;
        note_d  = note_q;
        len_d   = len_q;
        wd_d    = wd_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = N_REQ'(1) << win_idx;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (win_idx == IDX_W'(i)) begin
                            oct_d  = req_octave[i*OCT_W +: OCT_W];
                            note_d = req_note[i*NOTE_W +: NOTE_W];
                            len_d  = req_length[i*LEN_W +: LEN_W];
                        end
                    end
                    wd_d    = '0;
                    abort_d = 1'b0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT_ACK;
            // An over already low here (player busy elsewhere) counts as the ack.
            S_WAIT_ACK: begin
                wd_d = wd_inc;
                if (expired) begin
                    abort_d = 1'b1;
                    state_d = S_FINISH;
                end else if (!snd_over) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                wd_d = wd_inc;
                if (expired) begin
                    abort_d = 1'b1;
                    state_d = S_FINISH;
                end else if (snd_over) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                grant_d = '0;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            oct_q   <= '0;
            note_q  <= '0;
            len_q   <= '0;
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            oct_q   <= oct_d;
            note_q  <= note_d;
            len_q   <= len_d;
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end

    // snd_* keep the last note after FINISH so Light can keep showing it.
    assign grant      = grant_q;
    assign snd_octave = oct_q;
    assign snd_note   = note_q;
    assign snd_length = len_q;
    assign busy       = (state_q != S_IDLE);
    assign snd_start  = (state_q == S_LAUNCH);
    assign done       = (state_q == S_FINISH) ? grant_q : '0;
    assign abort      = (state_q == S_FINISH) && abort_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb/tb_sound_arbiter.sv - bench for sound_arbiter with a note-level reference model.
module tb_sound_arbiter;
    localparam int N  = 3;
    localparam int OW = 3;
    localparam int NW = 3;
    localparam int LW = 3;
    localparam int T  = 16;
    localparam int TW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*OW-1:0] req_octave;
    logic [N*NW-1:0] req_note;
    logic [N*LW-1:0] req_length;
    logic            snd_over;
    logic [N-1:0]    grant, done;
    logic            abort, snd_start, busy;
    logic [OW-1:0]   snd_octave;
    logic [NW-1:0]   snd_note;
    logic [LW-1:0]   snd_length;

    always #5 clk = ~clk;

    sound_arbiter #(.N_REQ(N), .OCT_W(OW), .NOTE_W(NW), .LEN_W(LW),
                    .TIMEOUT(T), .TO_W(TW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_octave(req_octave),
        .req_note(req_note), .req_length(req_length), .snd_over(snd_over),
        .grant(grant), .done(done), .abort(abort), .snd_start(snd_start),
        .snd_octave(snd_octave), .snd_note(snd_note), .snd_length(snd_length),
        .busy(busy));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: owner index, cycles since the grant edge, ack seen, finish pending.
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_ptr   = 0;
    bit          m_acked = 0;
    bit          m_fin   = 0;
    bit          m_abt   = 0;
    logic [OW-1:0] m_oct  = '0;
    logic [NW-1:0] m_note = '0;
    logic [LW-1:0] m_len  = '0;

    function automatic int pick(input logic [N-1:0] r, input int start);
`ifdef SOUND_ARB_RR_EN
        for (int i = 0; i < N; i++) if (r[(start + i) % N]) return (start + i) % N;
`else
        for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_acked = 0; m_fin = 0; m_abt = 0;
            m_oct = '0; m_note = '0; m_len = '0;
        end else if (m_fin) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_fin   = 0;
            m_abt   = 0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                m_owner = pick(req, m_ptr);
                m_oct   = req_octave[m_owner*OW +: OW];
                m_note  = req_note[m_owner*NW +: NW];
                m_len   = req_length[m_owner*LW +: LW];
                m_age   = 0;
                m_acked = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            // watchdog value is m_age-1: it starts counting once LAUNCH is over
            if (m_age - 1 >= T - 1) begin
                m_fin = 1;
                m_abt = 1;
            end else if (!m_acked) begin
                if (!snd_over) m_acked = 1;
            end else if (snd_over) begin
                m_fin = 1;
            end
            m_age++;
        end
    end

    int cyc = 0;
    int n_start = 0, n_done = 0, n_abort = 0;
    int done_cyc = 0, abort_cyc = 0;
    logic [N-1:0] last_done = '0;
    logic [N-1:0] glog[$];
    int           gcyc[$];

    task automatic monitor();
        logic [N-1:0] pg;
        int eg;
        pg = '0;
        forever begin
            @(negedge clk);
            cyc++;
            eg = (m_owner >= 0) ? (1 << m_owner) : 0;
            chk("grant", grant, eg);
            chk("busy", busy, m_owner >= 0);
            chk("snd_start", snd_start, (m_owner >= 0) && (m_age == 0) && !m_fin);
            chk("done", done, m_fin ? eg : 0);
            chk("abort", abort, m_fin && m_abt);
            chk("snd_octave", snd_octave, m_oct);
            chk("snd_note", snd_note, m_note);
            chk("snd_length", snd_length, m_len);
            if (snd_start) n_start++;
            if (|done) begin n_done++; done_cyc = cyc; last_done = done; end
            if (abort) begin n_abort++; abort_cyc = cyc; end
            if (grant != 0 && pg == 0) begin glog.push_back(grant); gcyc.push_back(cyc); end
            pg = grant;
        end
    endtask

    bit player_en = 0, auto_drop = 1, drop_pend = 0;
    int play_len = 10, play_cnt = 0;

    // One clock; inputs change 2 time units after the edge. Requesters drop on done.
    task automatic step();
        logic [N-1:0] clr;
        clr = auto_drop ? done : '0;
        @(posedge clk);
        #2;
        req = req & ~clr;
        if (player_en) begin
            if (play_cnt > 0) begin
                play_cnt--;
                if (play_cnt == 0) snd_over = 1'b1;
            end
            if (drop_pend) begin snd_over = 1'b0; drop_pend = 0; play_cnt = play_len; end
            if (snd_start) drop_pend = 1;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int b;
        b = 0;
        while (n_done < target && b < budget) begin step(); b++; end
        chk(name, n_done >= target, 1);
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_player();
        snd_over = 1'b1; drop_pend = 0; play_cnt = 0;
    endtask

    int bg, bd, bs, ba, d1, gsz;
    logic [N-1:0] exp_seq[4];

    initial begin
        req = '0; req_octave = '0; req_note = '0; req_length = '0; snd_over = 1'b1;
        rst = 1'b0;
        fork monitor(); join_none
        #1 rst = 1'b1;
        #2;
        chk("reset grant", grant, 0);
        chk("reset busy", busy, 0);
        chk("reset snd_start", snd_start, 0);
        chk("reset done", done, 0);
        chk("reset snd_note", snd_note, 0);
        step(); step();
        rst = 1'b0;
        idle(2);

        // single request with a 10-cycle note
        bg = glog.size(); bd = n_done; bs = n_start; ba = n_abort;
        req_note[2:0] = 3'd5; req_octave[2:0] = 3'd4; req_length[2:0] = 3'd2;
        player_en = 1; play_len = 10; auto_drop = 1; reset_player();
        req = 3'b001;
        wait_done(bd + 1, 60, "single done timeout");
        idle(3);
        chk("single grant", glog[bg], 3'b001);
        chk("single start count", n_start - bs, 1);
        chk("single done value", last_done, 3'b001);
        chk("single abort count", n_abort - ba, 0);
        chk("single latency", done_cyc - gcyc[bg], 12);
        chk("single held note", snd_note, 5);
        chk("single held octave", snd_octave, 4);
        chk("single held length", snd_length, 2);

        // contention, requesters hold through their done
        bg = glog.size(); bd = n_done;
        play_len = 2; auto_drop = 0; reset_player();
        req = 3'b110;
        wait_done(bd + 2, 60, "contention done timeout");
        idle(4);
        chk("contention grant count", glog.size() - bg, 2);
        chk("contention grant 0", glog[bg], 3'b010);
`ifdef SOUND_ARB_RR_EN
        chk("contention grant 1", glog[bg+1], 3'b100);
`else
        chk("contention grant 1", glog[bg+1], 3'b010);
`endif

        bg = glog.size(); bd = n_done;
        reset_player();
        req = 3'b111;
        wait_done(bd + 4, 80, "all-request done timeout");
        idle(4);
`ifdef SOUND_ARB_RR_EN
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        chk("all-request grant count", glog.size() - bg, 4);
        for (int i = 0; i < 4; i++) chk("all-request sequence", glog[bg+i], exp_seq[i]);

        // watchdog: player never acknowledges
        bg = glog.size(); bd = n_done; ba = n_abort;
        player_en = 0; auto_drop = 1; reset_player();
        req = 3'b001;
        wait_done(bd + 1, 60, "watchdog done timeout");
        idle(3);
        chk("watchdog pulse cycle", done_cyc - gcyc[bg] + 1, T + 2);
        chk("watchdog abort with done", abort_cyc, done_cyc);
        chk("watchdog abort count", n_abort - ba, 1);
        chk("watchdog back to idle", busy, 0);

        // mid-note slice change and a late lower-priority request
        bg = glog.size(); bd = n_done;
        player_en = 1; play_len = 6; reset_player();
        req_note = '0; req_note[2:0] = 3'd3; req_note[5:3] = 3'd6;
        req = 3'b001;
        for (int b = 0; b < 10 && snd_over; b++) step();
        step(); step();
        req_note[2:0] = 3'd7;
        req[1] = 1'b1;
        step(); step();
        chk("mid-note snd_note", snd_note, 3);
        wait_done(bd + 1, 40, "mid-note first done timeout");
        d1 = done_cyc;
        wait_done(bd + 2, 40, "mid-note second done timeout");
        idle(3);
        chk("mid-note first owner", glog[bg], 3'b001);
        chk("mid-note second owner", glog[bg+1], 3'b010);
        chk("mid-note grant after done", gcyc[bg+1] - d1 >= 2, 1);
        chk("mid-note held note", snd_note, 6);

        // asynchronous reset in PLAY
        bd = n_done;
        req_note[2:0] = 3'd2; reset_player();
        req = 3'b001;
        for (int b = 0; b < 10 && snd_over; b++) step();
        step(); step();
        #1 rst = 1'b1;
        #1;
        chk("async reset grant", grant, 0);
        chk("async reset busy", busy, 0);
        chk("async reset snd_note", snd_note, 0);
        chk("async reset done", done, 0);
        reset_player();
        gsz = glog.size();
        step(); step();
        rst = 1'b0;
        chk("reset no done", n_done, bd);
        wait_done(bd + 1, 40, "post-reset done timeout");
        chk("post-reset regrant", glog.size() > gsz, 1);
        chk("post-reset owner", glog[glog.size()-1], 3'b001);
        idle(3);

        // random traffic, player status toggling freely
        player_en = 0; auto_drop = 1;
        for (int c = 0; c < 700; c++) begin
            step();
            if ($urandom_range(3) == 0) snd_over = ~snd_over;
            if ($urandom_range(7) == 0) req = req | 3'($urandom_range(7));
            req_octave = 9'($urandom);
            req_note   = 9'($urandom);
            req_length = 9'($urandom);
        end
        snd_over = 1'b1;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
